// File: rtl/freq_disp_pkg.sv
// Shared types and constants for the frequency display slice.
// Holds the converter FSM states, segment table and display limits.
package freq_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    localparam int DIGITS   = 8;
    localparam int SCAN_DIV = 100;
    localparam int BIN_W    = 27;

    localparam logic [31:0] MAX_DISP = 32'd99_999_999;

    localparam logic [6:0] SEG_CODE [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // Map a BCD nibble to segments a..g; non-decimal nibbles go dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_CODE[0];
            4'd1:    s = SEG_CODE[1];
            4'd2:    s = SEG_CODE[2];
            4'd3:    s = SEG_CODE[3];
            4'd4:    s = SEG_CODE[4];
            4'd5:    s = SEG_CODE[5];
            4'd6:    s = SEG_CODE[6];
            4'd7:    s = SEG_CODE[7];
            4'd8:    s = SEG_CODE[8];
            4'd9:    s = SEG_CODE[9];
            default: s = 7'h00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/freq_display_bin2bcd_seq.sv
// Sequential double-dabble converter: clamp, 27 shift-add-3 steps,
// then a one-cycle done pulse with the BCD result and overflow flag.
module bin2bcd_seq
    import freq_disp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] din,
    output logic        busy,
    output logic        done,
    output logic [31:0] bcd,
    output logic        ovf_pend,
    output logic [31:0] raw
);

    state_t            state;
    state_t            state_nxt;
    logic [BIN_W-1:0]  bin;
    logic [31:0]       scratch;
    logic [31:0]       adj;
    logic [4:0]        cnt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (cnt == 5'd1) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Add 3 to every scratch nibble of 5 or more before shifting
    always_comb begin
        adj = scratch;
        for (int i = 0; i < 8; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    // Datapath: latch clamped input, shift bits in MSB first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin      <= '0;
            scratch  <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            ovf_pend <= 1'b0;
            raw      <= '0;
        end else begin
            case (state)
                LOAD: begin
                    bin      <= (din > MAX_DISP) ? MAX_DISP[BIN_W-1:0]
                                                 : din[BIN_W-1:0];
                    ovf_pend <= (din > MAX_DISP);
                    scratch  <= '0;
                    cnt      <= 5'(BIN_W);
                    busy     <= 1'b1;
                    raw      <= din;
                end
                SHIFT: begin
                    {scratch, bin} <= {adj[30:0], bin, 1'b0};
                    cnt            <= cnt - 5'd1;
                end
                DONE: begin
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign done = (state == DONE);
    assign bcd  = scratch;

endmodule

// File: rtl/freq_display.sv
// 8-digit multiplexed 7-segment display of the measured frequency.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits above the leading one.
module freq_display
    import freq_disp_pkg::*;
(
    input  logic        clk_100kHz,
    input  logic        rst_,
    input  logic [31:0] freq_real,
    output logic [7:0]  seg,
    output logic [7:0]  an,
    output logic        busy,
    output logic        ovf
);

    logic              start;
    logic              done;
    logic [31:0]       bcd;
    logic              ovf_pend;
    logic [31:0]       raw;
    logic [31:0]       last_conv;
    logic [31:0]       disp;
    logic [DIGITS-1:0] blank;
    logic [DIGITS-1:0] blank_nxt;
    logic [6:0]        presc;
    logic [2:0]        idx;
    logic [3:0]        cur_digit;
    logic [6:0]        cur_code;

    // A new measurement is any value differing from the last one shown
    assign start = (freq_real != last_conv);

    bin2bcd_seq u_conv (
        .clk      (clk_100kHz),
        .rst_n    (rst_),
        .start    (start),
        .din      (freq_real),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .ovf_pend (ovf_pend),
        .raw      (raw)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic lead;

    // Blank each digit above the most significant non-zero one
    always_comb begin
        blank_nxt = '0;
        lead      = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lead         = lead & (bcd[4*i +: 4] == 4'd0);
            blank_nxt[i] = lead;
        end
    end
`else
    // Every digit is always shown
    always_comb begin
        blank_nxt = '0;
    end
`endif

    // Commit a finished conversion to the display registers
    always_ff @(posedge clk_100kHz or negedge rst_) begin
        if (!rst_) begin
            disp      <= '0;
            blank     <= '0;
            ovf       <= 1'b0;
            last_conv <= '0;
        end else if (done) begin
            disp      <= bcd;
            blank     <= blank_nxt;
            ovf       <= ovf_pend;
            last_conv <= raw;
        end
    end

    // Select the digit for the current slot and decode it
    always_comb begin
        cur_digit = disp[{idx, 2'b00} +: 4];
        cur_code  = blank[idx] ? 7'h00 : seg_decode(cur_digit);
    end

    // Scan prescaler: advance to the next digit slot on each wrap
    always_ff @(posedge clk_100kHz or negedge rst_) begin
        if (!rst_) begin
            presc <= '0;
            idx   <= '0;
            an    <= 8'hFF;
            seg   <= 8'h00;
        end else if (presc == 7'(SCAN_DIV - 1)) begin
            presc <= '0;
            idx   <= idx + 3'd1;
            an    <= ~(8'd1 << idx);
            seg   <= {ovf, cur_code};
        end else begin
            presc <= presc + 7'd1;
        end
    end

endmodule

// File: tb/tb_freq_display.sv
// Self-checking bench for freq_display: table vectors, corner sequences
// and random values checked against a decimal-arithmetic display model.
module tb_freq_display;

    logic        clk_100kHz = 1'b0;
    logic        rst_;
    logic [31:0] freq_real;
    logic [7:0]  seg;
    logic [7:0]  an;
    logic        busy;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    freq_display dut (
        .clk_100kHz (clk_100kHz),
        .rst_       (rst_),
        .freq_real  (freq_real),
        .seg        (seg),
        .an         (an),
        .busy       (busy),
        .ovf        (ovf)
    );

    always #5 clk_100kHz = ~clk_100kHz;

    typedef struct {
        logic [31:0] v;
        logic [7:0]  s0;
        logic [7:0]  s7;
        logic        ov;
    } vec_t;

    task automatic tick(input int n);
        repeat (n) @(negedge clk_100kHz);
    endtask

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected segment byte for digit d when value v is displayed
    function automatic logic [7:0] exp_seg(input logic [31:0] v,
                                           input int d);
        logic [6:0]  tbl [10];
        logic [31:0] c;
        logic [31:0] p;
        int          dig;
        logic        blk;
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        c = (v > 32'd99_999_999) ? 32'd99_999_999 : v;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        dig = int'((c / p) % 10);
        blk = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        blk = (d > 0) && (c < p);
`endif
        return {v > 32'd99_999_999, blk ? 7'h00 : tbl[dig]};
    endfunction

    // Expected packed BCD value held in the display registers
    function automatic logic [31:0] exp_bcd(input logic [31:0] v);
        logic [31:0] c;
        logic [31:0] r;
        c = (v > 32'd99_999_999) ? 32'd99_999_999 : v;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(c % 10);
            c = c / 10;
        end
        return r;
    endfunction

    // Drive a value and check busy rises 2 and falls 30 negedges later
    task automatic convert(input logic [31:0] v);
        int rise;
        int fall;
        rise = -1;
        fall = -1;
        freq_real = v;
        for (int k = 1; k <= 40; k++) begin
            tick(1);
            if (busy && rise < 0) rise = k;
            if (!busy && rise >= 0 && fall < 0) fall = k;
        end
        check("busy_rise", 64'(rise), 64'd2);
        check("busy_fall", 64'(fall), 64'd30);
        check("disp_regs", 64'(dut.disp), 64'(exp_bcd(v)));
        check("ovf", 64'(ovf), 64'(v > 32'd99_999_999));
    endtask

    // Watch one full frame and check every digit slot against the model
    task automatic scan_frame(input logic [31:0] v,
                              output logic [63:0] segs);
        logic [7:0] prev;
        logic [7:0] seen;
        int         d;
        segs = '0;
        seen = '0;
        tick(100);
        prev = an;
        for (int c = 0; c < 800; c++) begin
            tick(1);
            if (an != prev) begin
                prev = an;
                if ($countones(~an) != 1) begin
                    check("an_onehot", 64'(an), 64'hFE);
                end else begin
                    d = 0;
                    for (int i = 0; i < 8; i++) if (!an[i]) d = i;
                    seen[d] = 1'b1;
                    segs[8*d +: 8] = seg;
                    check($sformatf("seg_d%0d", d), 64'(seg),
                          64'(exp_seg(v, d)));
                end
            end
        end
        check("frame_seen", 64'(seen), 64'hFF);
    endtask

    vec_t        vt [7];
    logic [63:0] segs;
    logic [31:0] v;
    logic [31:0] prev_v;
    int          k;
    logic        glitch;
    logic [7:0]  lz;

    initial begin
`ifdef LEADING_ZERO_BLANK_EN
        lz = 8'h00;
`else
        lz = 8'h3F;
`endif
        vt[0] = '{32'd12_345_678,  8'h7F, 8'h06, 1'b0};
        vt[1] = '{32'hFFFF_FFFF,   8'hEF, 8'hEF, 1'b1};
        vt[2] = '{32'd1000,        8'h3F, lz,    1'b0};
        vt[3] = '{32'd40,          8'h3F, lz,    1'b0};
        vt[4] = '{32'd99_999_999,  8'h6F, 8'h6F, 1'b0};
        vt[5] = '{32'd100_000_000, 8'hEF, 8'hEF, 1'b1};
        vt[6] = '{32'd0,           8'h3F, lz,    1'b0};

        rst_      = 1'b0;
        freq_real = '0;
        tick(3);
        check("rst_an", 64'(an), 64'hFF);
        check("rst_seg", 64'(seg), 64'h00);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_ovf", 64'(ovf), 64'h0);
        rst_ = 1'b1;
        tick(99);
        check("pre_wrap_an", 64'(an), 64'hFF);
        tick(1);
        check("slot0_an", 64'(an), 64'hFE);
        check("slot0_seg", 64'(seg), 64'h3F);

        for (int i = 0; i < 7; i++) begin
            convert(vt[i].v);
            check("tbl_ovf", 64'(ovf), 64'(vt[i].ov));
            scan_frame(vt[i].v, segs);
            check("tbl_seg0", 64'(segs[7:0]), 64'(vt[i].s0));
            check("tbl_seg7", 64'(segs[63:56]), 64'(vt[i].s7));
        end

        // New value arriving mid-conversion is picked up afterwards
        freq_real = 32'd500;
        k = 0;
        while (!busy && k < 40) begin tick(1); k++; end
        check("cwb_start", 64'(busy), 64'h1);
        tick(6);
        freq_real = 32'd700;
        k = 0;
        while (busy && k < 40) begin tick(1); k++; end
        check("cwb_first", 64'(dut.disp), 64'h500);
        glitch = 1'b0;
        k = 0;
        while (!busy && k < 10) begin tick(1); k++; end
        check("cwb_restart", 64'(busy), 64'h1);
        k = 0;
        while (busy && k < 40) begin
            if (dut.disp != 32'h500) glitch = 1'b1;
            tick(1);
            k++;
        end
        check("cwb_no_glitch", 64'(glitch), 64'h0);
        check("cwb_final", 64'(dut.disp), 64'h700);
        scan_frame(32'd700, segs);

        // Reset in the middle of a conversion
        freq_real = 32'd99_999;
        k = 0;
        while (!busy && k < 40) begin tick(1); k++; end
        tick(10);
        rst_ = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'h0);
        check("mid_rst_an", 64'(an), 64'hFF);
        check("mid_rst_seg", 64'(seg), 64'h00);
        check("mid_rst_ovf", 64'(ovf), 64'h0);
        check("mid_rst_disp", 64'(dut.disp), 64'h0);
        tick(2);
        rst_ = 1'b1;
        convert(32'd99_999);
        scan_frame(32'd99_999, segs);

        // Random values against the decimal model
        prev_v = 32'd99_999;
        for (int i = 0; i < 6; i++) begin
            case ($urandom_range(0, 2))
                0:       v = $urandom;
                1:       v = $urandom_range(0, 99_999_999);
                default: v = $urandom_range(0, 999);
            endcase
            if (v == prev_v) v = v ^ 32'h1;
            prev_v = v;
            convert(v);
            scan_frame(v, segs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/freq_display.md
Name: freq_display

Overview:
- Downstream of the frequency-measurement stage. Consumes its 32-bit `freq_real` result, in Hz.
- Converts that result to 8 BCD digits with a sequential shift-add-3 (double-dabble) converter.
- Drives a time-multiplexed 8-digit common-anode 7-segment display.
- Runs entirely in the 100 kHz measurement clock domain.

Parameters:
- DIGITS, 8, number of displayed decimal digits (fixed at 8 for this revision).
- SCAN_DIV, 100, clk_100kHz cycles per digit slot (1 kHz digit rate, 125 Hz frame rate).
- MAX_DISP, 99_999_999, largest displayable value; larger inputs saturate.

Ports:
- clk_100kHz  input  1  system clock, 100 kHz.
- rst_  input  1  asynchronous active-low reset.
- freq_real  input  32  measured frequency in Hz, held stable between measurement updates.
- seg  output  8  segment drive, active-high; [0]=a … [6]=g, [7]=dp.
- an  output  8  digit enable, active-low one-hot; an[0] = least significant digit.
- busy  output  1  high while a BCD conversion is in progress.
- ovf  output  1  high while the displayed value is saturated.

Behaviour:
- Reset values: seg=8'h00, an=8'hFF, busy=0, ovf=0, all display BCD registers 0, digit index 0, prescaler 0, last-converted register 0, FSM in IDLE.
- The clock is clk_100kHz; reset is asynchronous and active-low on rst_.
- A reset asserted mid-conversion aborts the conversion, restores all reset values and blanks the display.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE -> LOAD: when freq_real != last_conv register.
- LOAD, 1 cycle:
  - Latch the clamped value: min(freq_real, MAX_DISP), 27 bits.
  - Set ovf_pending = (freq_real > MAX_DISP).
  - Clear the 32-bit BCD scratch.
  - Set iteration count = 27; busy = 1.
- SHIFT, 27 cycles, one per bit:
  - Add 3 to each scratch nibble that is >= 5.
  - Then shift {scratch, bin} left by 1, MSB of bin first.
- DONE, 1 cycle:
  - Copy scratch to the display registers and ovf_pending to ovf.
  - last_conv = freq_real as latched in LOAD, unclamped.
  - busy = 0; go to IDLE.
- Latency: a freq_real change sampled in IDLE at edge N updates the display registers at edge N+29.
- freq_real changes while busy are ignored. Because IDLE compares against last_conv, the newest value is picked up on the first IDLE cycle after DONE. Intermediate values are lost.
- Scan prescaler counts 0..SCAN_DIV-1. On wrap, digit index = (index+1) mod DIGITS.
- an = ~(1 << index), registered.
- seg = decode(display digit[index]), registered. Digit and segment change on the same edge.
- Segment codes (seg[6:0]):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Nibbles >9 never occur; decode them as 00.
- dp (seg[7]) = ovf on every digit.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Digits above the most significant non-zero digit drive seg[6:0]=00; dp still follows ovf.
  - Digit 0 always shows, so a value of 0 displays "0".
  - The blank mask is computed in DONE and registered with the digits.
- Undefined: all 8 digits are always shown, leading zeros included.

Decomposition:
- Package freq_disp_pkg:
  - FSM state enum.
  - SEG_CODE[0:9] constant table.
  - MAX_DISP and the BIN_W=27 constant.
- Sub-module bin2bcd_seq holds LOAD/SHIFT/DONE, the scratch register and the iteration counter.
  - Handshake: start/busy/done pulse.
  - freq_display keeps the change detector, ovf and last_conv logic, scan prescaler, digit mux, decoder and blanking.

Test Plan:
- Reset: hold rst_=0 at power-up, then release -> an=FF, seg=00, busy=0, ovf=0. First digit slot an=FE, seg=3F, one cycle after the first prescaler wrap.
- Basic conversion: freq_real=12_345_678 -> busy high for 28 cycles; display registers = 8'h12345678 BCD after 29 edges.
  - Over one 800-cycle frame, an[0] pairs with seg=7F ('8') and an[7] with seg=06 ('1').
- Overflow: freq_real=32'hFFFF_FFFF -> all digits seg[6:0]=6F ('9'), seg[7]=1, ovf=1.
  - Then freq_real=1000 -> ovf=0 after conversion.
- Change while busy: freq_real 500 -> 700 at cycle 5 of SHIFT -> first result 500.
  - Conversion restarts the next IDLE cycle; final display shows 700; no display glitch in between.
- Blanking, LEADING_ZERO_BLANK_EN defined:
  - freq_real=40 -> digits 2..7 seg=00, digit1=66, digit0=3F.
  - freq_real=0 -> only digit0 shows 3F.
  - With the macro undefined: freq_real=40 -> digits 2..7 seg=3F.
- Reset mid-conversion: assert rst_ at the 10th SHIFT cycle of freq_real=99_999 -> immediate reset values.
  - After release, the same freq_real reconverts (last_conv is 0) and displays 99999.
